mips_alu_reg: RTL and testbench

- 32-bit MIPS-style integer ALU with registered outputs.
- Selects one of 13 operations by a 4-bit opcode: shifts, multiply, divide, add/sub with flags, logic, set-less-than.
- Produces a primary result, a secondary result (mul high word / div remainder), overflow, carry and equality flags.
- Sits in the execute stage between the register-read operands and the writeback mux.

---
 rtl/mips_alu_reg.sv | 130 +++++++++++++
 tb/tb_mips_alu_reg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu_reg.sv
// rtl/mips_alu_reg.sv - 32-bit MIPS-style integer ALU with one-cycle registered outputs.
// Multiply/divide (opcodes 3 and 4) is built only when ALU_MULDIV_EN is defined.
module mips_alu_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] sr,
  input  logic [31:0] tg,
  input  logic [3:0]  ALUop,
  output logic        out_valid,
  output logic [31:0] result1,
  output logic [31:0] result2,
  output logic        OF,
  output logic        CF,
  output logic        Equal
);

  typedef enum logic [3:0] {
    OP_SLL  = 4'd0,
    OP_SRA  = 4'd1,
    OP_SRL  = 4'd2,
    OP_MUL  = 4'd3,
    OP_DIV  = 4'd4,
    OP_ADD  = 4'd5,
    OP_SUB  = 4'd6,
    OP_AND  = 4'd7,
    OP_OR   = 4'd8,
    OP_XOR  = 4'd9,
    OP_NOR  = 4'd10,
    OP_SLT  = 4'd11,
    OP_SLTU = 4'd12
  } alu_op_e;

  logic [4:0]  shamt;
  logic [32:0] sum;
  logic [32:0] diff;
  logic        slt_signed;

  assign shamt      = tg[4:0];
  assign sum        = {1'b0, sr} + {1'b0, tg};
  assign diff       = {1'b0, sr} - {1'b0, tg};
  assign slt_signed = ($signed(sr) < $signed(tg));

`ifdef ALU_MULDIV_EN
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  assign prod = {32'b0, sr} * {32'b0, tg};
  // Divide by zero returns all-ones quotient and passes the dividend through as remainder.
  assign quot = (tg == 32'd0) ? 32'hFFFF_FFFF : sr / tg;
  assign rem  = (tg == 32'd0) ? sr : sr % tg;
`endif

  logic        out_valid_q;
  logic [31:0] result1_q, result1_d;
  logic [31:0] result2_q, result2_d;
  logic        of_q, of_d;
  logic        cf_q, cf_d;
  logic        equal_q, equal_d;

  always_comb begin
    result1_d = 32'd0;
    result2_d = 32'd0;
    of_d      = 1'b0;
    cf_d      = 1'b0;
    equal_d   = (sr == tg);
    case (ALUop)
      OP_SLL:  result1_d = sr << shamt;
      OP_SRA:  result1_d = $unsigned($signed(sr) >>> shamt);
      OP_SRL:  result1_d = sr >> shamt;
`ifdef ALU_MULDIV_EN
      OP_MUL: begin
        result1_d = prod[31:0];
        result2_d = prod[63:32];
      end
      OP_DIV: begin
        result1_d = quot;
        result2_d = rem;
      end
`endif
      OP_ADD: begin
        result1_d = sum[31:0];
        cf_d      = sum[32];
        of_d      = (sr[31] == tg[31]) && (sum[31] != sr[31]);
      end
      OP_SUB: begin
        // diff[32] is the borrow, i.e. sr < tg unsigned.
        result1_d = diff[31:0];
        cf_d      = diff[32];
        of_d      = (sr[31] != tg[31]) && (diff[31] != sr[31]);
      end
      OP_AND:  result1_d = sr & tg;
      OP_OR:   result1_d = sr | tg;
      OP_XOR:  result1_d = sr ^ tg;
      OP_NOR:  result1_d = ~(sr | tg);
      OP_SLT:  result1_d = {31'd0, slt_signed};
      OP_SLTU: result1_d = {31'd0, diff[32]};
      default: result1_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result1_q   <= 32'd0;
      result2_q   <= 32'd0;
      of_q        <= 1'b0;
      cf_q        <= 1'b0;
      equal_q     <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result1_q <= result1_d;
        result2_q <= result2_d;
        of_q      <= of_d;
        cf_q      <= cf_d;
        equal_q   <= equal_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result1   = result1_q;
  assign result2   = result2_q;
  assign OF        = of_q;
  assign CF        = cf_q;
  assign Equal     = equal_q;

endmodule

// File: tb/tb_mips_alu_reg.sv
// tb/tb_mips_alu_reg.sv - directed plus randomized self-checking bench for mips_alu_reg.
// Expected values come from an arithmetic reference model; honours ALU_MULDIV_EN.
module tb_mips_alu_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] sr;
  logic [31:0] tg;
  logic [3:0]  ALUop;
  logic        out_valid;
  logic [31:0] result1;
  logic [31:0] result2;
  logic        OF;
  logic        CF;
  logic        Equal;

  int passed;
  int total;

  logic        e_v;
  logic [31:0] e_r1;
  logic [31:0] e_r2;
  logic        e_of;
  logic        e_cf;
  logic        e_eq;

  mips_alu_reg dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .sr(sr),
    .tg(tg),
    .ALUop(ALUop),
    .out_valid(out_valid),
    .result1(result1),
    .result2(result2),
    .OF(OF),
    .CF(CF),
    .Equal(Equal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r1, output logic [31:0] r2,
                                output logic of, output logic cf);
    longint      sa;
    longint      sb;
    longint      sres;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] ures;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r1 = 32'd0;
    r2 = 32'd0;
    of = 1'b0;
    cf = 1'b0;
    case (op)
      4'd0: r1 = a << b[4:0];
      4'd1: r1 = 32'(sa >>> b[4:0]);
      4'd2: r1 = a >> b[4:0];
`ifdef ALU_MULDIV_EN
      4'd3: begin
        ures = ua * ub;
        r1 = ures[31:0];
        r2 = ures[63:32];
      end
      4'd4: begin
        if (b == 32'd0) begin
          r1 = 32'hFFFF_FFFF;
          r2 = a;
        end else begin
          r1 = a / b;
          r2 = a % b;
        end
      end
`endif
      4'd5: begin
        ures = ua + ub;
        sres = sa + sb;
        r1 = ures[31:0];
        cf = (ures >= 64'h1_0000_0000);
        of = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'd6: begin
        sres = sa - sb;
        r1 = a - b;
        cf = (a < b);
        of = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'd7:  r1 = a & b;
      4'd8:  r1 = a | b;
      4'd9:  r1 = a ^ b;
      4'd10: r1 = ~(a | b);
      4'd11: r1 = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: r1 = (ua < ub) ? 32'd1 : 32'd0;
      default: r1 = 32'd0;
    endcase
  endfunction

  task automatic step(input logic r, input logic v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m1;
    logic [31:0] m2;
    logic        mo;
    logic        mc;
    rst = r;
    in_valid = v;
    ALUop = op;
    sr = a;
    tg = b;
    @(posedge clk);
    #1;
    if (r) begin
      e_v = 1'b0; e_r1 = 32'd0; e_r2 = 32'd0; e_of = 1'b0; e_cf = 1'b0; e_eq = 1'b0;
    end else begin
      e_v = v;
      if (v) begin
        model(op, a, b, m1, m2, mo, mc);
        e_r1 = m1; e_r2 = m2; e_of = mo; e_cf = mc;
        e_eq = (a == b);
      end
    end
    chk($sformatf("out_valid op=%0d", op), {31'd0, out_valid}, {31'd0, e_v});
    chk($sformatf("result1 op=%0d a=%h b=%h", op, a, b), result1, e_r1);
    chk($sformatf("result2 op=%0d a=%h b=%h", op, a, b), result2, e_r2);
    chk($sformatf("OF op=%0d a=%h b=%h", op, a, b), {31'd0, OF}, {31'd0, e_of});
    chk($sformatf("CF op=%0d a=%h b=%h", op, a, b), {31'd0, CF}, {31'd0, e_cf});
    chk($sformatf("Equal op=%0d", op), {31'd0, Equal}, {31'd0, e_eq});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    passed = 0;
    total = 0;
    rst = 1'b1; in_valid = 1'b0; ALUop = 4'd0; sr = 32'd0; tg = 32'd0;

    // Reset with a valid op presented: reset must win.
    step(1'b1, 1'b1, 4'd5, 32'd1, 32'd1);
    step(1'b1, 1'b1, 4'd5, 32'd1, 32'd1);
    chk("reset result1", result1, 32'd0);
    chk("reset Equal", {31'd0, Equal}, 32'd0);

    step(1'b0, 1'b1, 4'd5, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add ovf result1", result1, 32'h8000_0000);
    chk("add ovf OF", {31'd0, OF}, 32'd1);
    chk("add ovf CF", {31'd0, CF}, 32'd0);
    step(1'b0, 1'b0, 4'd6, 32'd3, 32'd9);
    chk("hold result1", result1, 32'h8000_0000);
    chk("hold out_valid", {31'd0, out_valid}, 32'd0);

    step(1'b0, 1'b1, 4'd0, 32'h0000_0001, 32'h0000_001F);
    chk("sll 31", result1, 32'h8000_0000);
    step(1'b0, 1'b1, 4'd1, 32'hFFFF_FFFF, 32'd1);
    step(1'b0, 1'b1, 4'd1, 32'h7FFF_FFFF, 32'd1);
    chk("sra pos", result1, 32'h3FFF_FFFF);
    step(1'b0, 1'b1, 4'd2, 32'h8000_0000, 32'd1);
    chk("srl", result1, 32'h4000_0000);

    step(1'b0, 1'b1, 4'd6, 32'd0, 32'd1);
    chk("sub borrow CF", {31'd0, CF}, 32'd1);
    step(1'b0, 1'b1, 4'd6, 32'h8000_0000, 32'd1);
    chk("sub ovf OF", {31'd0, OF}, 32'd1);
    step(1'b0, 1'b1, 4'd5, 32'hFFFF_FFFF, 32'd1);
    chk("add carry CF", {31'd0, CF}, 32'd1);

    step(1'b0, 1'b1, 4'd3, 32'h10, 32'h10);
    step(1'b0, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'd2);
`ifdef ALU_MULDIV_EN
    chk("mul hi", result2, 32'd1);
`else
    chk("mul disabled", result1, 32'd0);
`endif
    step(1'b0, 1'b1, 4'd4, 32'd7, 32'd3);
    step(1'b0, 1'b1, 4'd4, 32'd5, 32'd0);
`ifdef ALU_MULDIV_EN
    chk("div0 quot", result1, 32'hFFFF_FFFF);
    chk("div0 rem", result2, 32'd5);
`else
    chk("div disabled", result2, 32'd0);
`endif

    step(1'b0, 1'b1, 4'd7, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    step(1'b0, 1'b1, 4'd8, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    step(1'b0, 1'b1, 4'd9, 32'hAAAA_5555, 32'hFFFF_0000);
    chk("xor", result1, 32'h5555_5555);
    step(1'b0, 1'b1, 4'd10, 32'd0, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 4'd11, 32'hFFFF_FFFF, 32'd1);
    chk("slt neg", result1, 32'd1);
    step(1'b0, 1'b1, 4'd11, 32'd1, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 4'd12, 32'd1, 32'hFFFF_FFFF);
    chk("sltu", result1, 32'd1);
    step(1'b0, 1'b1, 4'd12, 32'hFFFF_FFFF, 32'd1);

    step(1'b0, 1'b1, 4'd5, 32'h1234_5678, 32'h1234_5678);
    chk("b2b add", result1, 32'h2468_ACF0);
    step(1'b0, 1'b1, 4'd6, 32'h1234_5678, 32'h1234_5678);
    step(1'b0, 1'b1, 4'd13, 32'h1234_5678, 32'h1234_5678);
    chk("b2b op13 Equal", {31'd0, Equal}, 32'd1);

    for (int i = 0; i < 300; i++) begin
      ra = pick_operand();
      rb = ($urandom_range(0, 7) == 0) ? ra : pick_operand();
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), ra, rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
